// File: rtl/sd_bus_pkg.sv
// Shared types for the SD register bus arbiter: FSM states, port ids, default widths.
// Combinational helpers only; no latency or backpressure of its own.
package sd_bus_pkg;

   localparam int DEF_ADDR_W = 7;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_RD_LAT = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RD_WAIT = 2'd2,
      ACK     = 2'd3
   } state_t;

   typedef enum logic {
      PORT_HOST = 1'b0,
      PORT_ENG  = 1'b1
   } port_t;

   // Two-way round robin choice; only meaningful when at least one req bit is set.
   function automatic port_t rr_pick(input logic [1:0] req, input port_t last);
      port_t pick;
      pick = PORT_HOST;
      if (req == 2'b11) begin
         pick = (last == PORT_HOST) ? PORT_ENG : PORT_HOST;
      end else if (req[1]) begin
         pick = PORT_ENG;
      end
      return pick;
   endfunction

endpackage

// File: rtl/sd_bus_arbiter_if.sv
// Host/engine request ports and SD controller register bus as one bundle.
// Slave modport is the arbiter; master modport is the requesters plus SD read data.
interface sd_bus_arbiter_if
   import sd_bus_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic              fpga_mode;

   logic              h_req;
   logic              h_we;
   logic [ADDR_W-1:0] h_addr;
   logic [DATA_W-1:0] h_wdata;
   logic              h_ack;
   logic [DATA_W-1:0] h_rdata;

   logic              e_req;
   logic              e_we;
   logic [ADDR_W-1:0] e_addr;
   logic [DATA_W-1:0] e_wdata;
   logic              e_ack;
   logic [DATA_W-1:0] e_rdata;

   logic [ADDR_W-1:0] sd_addr;
   logic              sd_we;
   logic [DATA_W-1:0] sd_data_o;
   logic [DATA_W-1:0] sd_data_i;

   logic              busy;
   logic              owner;

   modport slave (
      input  fpga_mode,
      input  h_req, h_we, h_addr, h_wdata,
      input  e_req, e_we, e_addr, e_wdata,
      input  sd_data_i,
      output h_ack, h_rdata,
      output e_ack, e_rdata,
      output sd_addr, sd_we, sd_data_o,
      output busy, owner
   );

   modport master (
      output fpga_mode,
      output h_req, h_we, h_addr, h_wdata,
      output e_req, e_we, e_addr, e_wdata,
      output sd_data_i,
      input  h_ack, h_rdata,
      input  e_ack, e_rdata,
      input  sd_addr, sd_we, sd_data_o,
      input  busy, owner
   );

endinterface

// File: rtl/sd_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational gnt from req and the last-granted pointer.
// Zero latency; pointer moves only when advance is high and something is granted.
module rr_arb2
   import sd_bus_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt,
   output port_t      last
);

   port_t pick;

   always_comb begin
      pick = rr_pick(req, last);
      gnt  = 2'b00;
      if (req != 2'b00) begin
         gnt = (pick == PORT_ENG) ? 2'b10 : 2'b01;
      end
   end

   // Engine-last out of reset so the host wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= PORT_ENG;
      end else if (advance && (req != 2'b00)) begin
         last <= pick;
      end
   end

endmodule

// File: rtl/sd_bus_arbiter.sv
// Arbitrates host and engine register accesses onto a single SD controller register bus.
// Write ack 2 cycles after grant sample, read ack 2+RD_LAT; requesters wait (req held) until ack.
module sd_bus_arbiter
   import sd_bus_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic            clk,
   input  logic            rst_n,
   sd_bus_arbiter_if.slave bus
);

   localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

   state_t            state;
   logic              lat_we;
   logic [1:0]        wait_cnt;

   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              grant;
   port_t             gnt_port;
   port_t             rr_last_unused;

   logic              g_we;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_wdata;

   // The engine is invisible to arbitration outside fpga_mode; its request just waits.
   assign req      = {bus.e_req & bus.fpga_mode, bus.h_req};
   assign grant    = (state == IDLE) && (gnt != 2'b00);
   assign gnt_port = gnt[1] ? PORT_ENG : PORT_HOST;

   always_comb begin
      g_we    = bus.h_we;
      g_addr  = bus.h_addr;
      g_wdata = bus.h_wdata;
      if (gnt[1]) begin
         g_we    = bus.e_we;
         g_addr  = bus.e_addr;
         g_wdata = bus.e_wdata;
      end
   end

   rr_arb2 u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .advance (grant),
      .gnt     (gnt),
      .last    (rr_last_unused)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         lat_we        <= 1'b0;
         wait_cnt      <= 2'd0;
         bus.h_ack     <= 1'b0;
         bus.e_ack     <= 1'b0;
         bus.h_rdata   <= '0;
         bus.e_rdata   <= '0;
         bus.sd_addr   <= '0;
         bus.sd_we     <= 1'b0;
         bus.sd_data_o <= '0;
         bus.busy      <= 1'b0;
         bus.owner     <= PORT_HOST;
      end else begin
         case (state)
            IDLE: begin
               // sd_addr/sd_data_o double as the latched request fields.
               if (grant) begin
                  bus.owner     <= gnt_port;
                  lat_we        <= g_we;
                  bus.sd_addr   <= g_addr;
                  bus.sd_data_o <= g_wdata;
                  bus.sd_we     <= g_we;
                  bus.busy      <= 1'b1;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               bus.sd_we <= 1'b0;
               wait_cnt  <= 2'd0;
               if (lat_we) begin
                  if (bus.owner == PORT_ENG) bus.e_ack <= 1'b1;
                  else                       bus.h_ack <= 1'b1;
                  state <= ACK;
               end else begin
                  state <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  if (bus.owner == PORT_ENG) begin
                     bus.e_rdata <= bus.sd_data_i;
                     bus.e_ack   <= 1'b1;
                  end else begin
                     bus.h_rdata <= bus.sd_data_i;
                     bus.h_ack   <= 1'b1;
                  end
                  state <= ACK;
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            ACK: begin
               bus.h_ack <= 1'b0;
               bus.e_ack <= 1'b0;
               bus.busy  <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_bus_arbiter.sv
// Bench for sd_bus_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Two DUTs share clock and reset: RD_LAT=1 (main) and RD_LAT=3 (latency scenario).
module tb_sd_bus_arbiter;

   localparam int LAT1 = 1;
   localparam int LAT3 = 3;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   sd_bus_arbiter_if #(.ADDR_W(7), .DATA_W(8)) b1 ();
   sd_bus_arbiter_if #(.ADDR_W(7), .DATA_W(8)) b3 ();

   sd_bus_arbiter #(.ADDR_W(7), .DATA_W(8), .RD_LAT(LAT1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b1)
   );

   sd_bus_arbiter #(.ADDR_W(7), .DATA_W(8), .RD_LAT(LAT3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      b1.fpga_mode = 0; b1.h_req = 0; b1.h_we = 0; b1.h_addr = 0; b1.h_wdata = 0;
      b1.e_req = 0; b1.e_we = 0; b1.e_addr = 0; b1.e_wdata = 0; b1.sd_data_i = 0;
      b3.fpga_mode = 0; b3.h_req = 0; b3.h_we = 0; b3.h_addr = 0; b3.h_wdata = 0;
      b3.e_req = 0; b3.e_we = 0; b3.e_addr = 0; b3.e_wdata = 0; b3.sd_data_i = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick(); tick();
      @(negedge clk);
      checks++;
      if ({b1.h_ack, b1.e_ack, b1.sd_we, b1.busy, b1.owner, b1.sd_addr, b1.sd_data_o, b1.h_rdata, b1.e_rdata} !== 39'd0) begin
         errors++;
         $display("FAIL reset_b1: got ack=%b%b we=%b busy=%b owner=%b addr=%h do=%h hr=%h er=%h, want all zero",
                  b1.h_ack, b1.e_ack, b1.sd_we, b1.busy, b1.owner, b1.sd_addr, b1.sd_data_o, b1.h_rdata, b1.e_rdata);
      end
      checks++;
      if ({b3.h_ack, b3.e_ack, b3.sd_we, b3.busy, b3.owner, b3.sd_addr, b3.sd_data_o, b3.h_rdata, b3.e_rdata} !== 39'd0) begin
         errors++;
         $display("FAIL reset_b3: outputs not at reset values");
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_host_write();
      b1.fpga_mode = 0; b1.h_req = 1; b1.h_we = 1; b1.h_addr = 7'h05; b1.h_wdata = 8'hA3;
      @(negedge clk);
      checks++;
      if (b1.sd_we !== 1'b0 || b1.busy !== 1'b0) begin
         errors++; $display("FAIL wr_cycle0: sd_we=%b busy=%b, want 0 0", b1.sd_we, b1.busy);
      end
      tick();
      @(negedge clk);
      checks++;
      if (b1.sd_we !== 1'b1 || b1.sd_addr !== 7'h05 || b1.sd_data_o !== 8'hA3 || b1.busy !== 1'b1 || b1.h_ack !== 1'b0) begin
         errors++; $display("FAIL wr_issue: we=%b addr=%h do=%h busy=%b ack=%b, want 1 05 a3 1 0",
                            b1.sd_we, b1.sd_addr, b1.sd_data_o, b1.busy, b1.h_ack);
      end
      tick();
      @(negedge clk);
      checks++;
      if (b1.h_ack !== 1'b1 || b1.e_ack !== 1'b0 || b1.sd_we !== 1'b0 || b1.owner !== 1'b0) begin
         errors++; $display("FAIL wr_ack: h_ack=%b e_ack=%b we=%b owner=%b, want 1 0 0 0",
                            b1.h_ack, b1.e_ack, b1.sd_we, b1.owner);
      end
      tick();
      b1.h_req = 0;
      @(negedge clk);
      checks++;
      if (b1.h_ack !== 1'b0 || b1.busy !== 1'b0 || b1.sd_addr !== 7'h05 || b1.sd_data_o !== 8'hA3) begin
         errors++; $display("FAIL wr_after: ack=%b busy=%b addr=%h do=%h, want 0 0 05 a3",
                            b1.h_ack, b1.busy, b1.sd_addr, b1.sd_data_o);
      end
      tick();
   endtask

   task automatic test_host_read();
      b1.h_req = 1; b1.h_we = 0; b1.h_addr = 7'h12; b1.sd_data_i = 8'h5C;
      tick();
      @(negedge clk);
      checks++;
      if (b1.sd_we !== 1'b0 || b1.sd_addr !== 7'h12 || b1.sd_data_o !== 8'hA3) begin
         errors++; $display("FAIL rd_issue: we=%b addr=%h do=%h, want 0 12 a3", b1.sd_we, b1.sd_addr, b1.sd_data_o);
      end
      tick();
      @(negedge clk);
      checks++;
      if (b1.h_ack !== 1'b0 || b1.busy !== 1'b1 || b1.sd_we !== 1'b0) begin
         errors++; $display("FAIL rd_wait: ack=%b busy=%b we=%b, want 0 1 0", b1.h_ack, b1.busy, b1.sd_we);
      end
      tick();
      @(negedge clk);
      checks++;
      if (b1.h_ack !== 1'b1 || b1.h_rdata !== 8'h5C || b1.sd_we !== 1'b0) begin
         errors++; $display("FAIL rd_ack: ack=%b rdata=%h we=%b, want 1 5c 0", b1.h_ack, b1.h_rdata, b1.sd_we);
      end
      tick();
      b1.h_req = 0; b1.sd_data_i = 8'h00;
      @(negedge clk);
      checks++;
      if (b1.h_ack !== 1'b0 || b1.h_rdata !== 8'h5C) begin
         errors++; $display("FAIL rd_hold: ack=%b rdata=%h, want 0 5c", b1.h_ack, b1.h_rdata);
      end
      tick();
   endtask

   task automatic test_engine_blocked();
      int bad;
      bad = 0;
      b1.fpga_mode = 0; b1.e_req = 1; b1.e_we = 1; b1.e_addr = 7'h33; b1.e_wdata = 8'h44;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (b1.e_ack !== 1'b0 || b1.sd_we !== 1'b0 || b1.busy !== 1'b0) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL eng_blocked: %0d cycles with activity, want 0", bad);
      end
      b1.fpga_mode = 1;
      tick();
      @(negedge clk);
      checks++;
      if (b1.sd_we !== 1'b1 || b1.sd_addr !== 7'h33 || b1.sd_data_o !== 8'h44) begin
         errors++; $display("FAIL eng_issue: we=%b addr=%h do=%h, want 1 33 44", b1.sd_we, b1.sd_addr, b1.sd_data_o);
      end
      tick();
      @(negedge clk);
      checks++;
      if (b1.e_ack !== 1'b1 || b1.h_ack !== 1'b0 || b1.owner !== 1'b1) begin
         errors++; $display("FAIL eng_ack: e_ack=%b h_ack=%b owner=%b, want 1 0 1", b1.e_ack, b1.h_ack, b1.owner);
      end
      tick();
      b1.e_req = 0;
      tick();
   endtask

   // Entered with the engine as last grant, so the host leads the alternation.
   task automatic test_back_to_back();
      logic p;
      b1.fpga_mode = 1;
      b1.h_req = 1; b1.h_we = 1; b1.h_addr = 7'h01; b1.h_wdata = 8'h10;
      b1.e_req = 1; b1.e_we = 1; b1.e_addr = 7'h02; b1.e_wdata = 8'h20;
      for (int k = 0; k < 4; k++) begin
         p = (k % 2) == 1;
         tick();
         @(negedge clk);
         checks++;
         if (b1.sd_we !== 1'b1 || b1.sd_addr !== (p ? 7'h02 : 7'h01)) begin
            errors++; $display("FAIL b2b_issue[%0d]: we=%b addr=%h, want 1 %h", k, b1.sd_we, b1.sd_addr, p ? 7'h02 : 7'h01);
         end
         tick();
         @(negedge clk);
         checks++;
         if (b1.h_ack !== !p || b1.e_ack !== p || b1.owner !== p) begin
            errors++; $display("FAIL b2b_ack[%0d]: h=%b e=%b owner=%b, want %b %b %b", k, b1.h_ack, b1.e_ack, b1.owner, !p, p, p);
         end
         tick();
      end
      b1.h_req = 0; b1.e_req = 0;
      tick();
   endtask

   task automatic test_reset_mid();
      b1.fpga_mode = 0; b1.h_req = 1; b1.h_we = 0; b1.h_addr = 7'h40; b1.sd_data_i = 8'h5A;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({b1.h_ack, b1.e_ack, b1.sd_we, b1.busy, b1.owner, b1.sd_addr, b1.sd_data_o, b1.h_rdata, b1.e_rdata} !== 39'd0) begin
         errors++; $display("FAIL rst_mid: busy=%b addr=%h hr=%h er=%h owner=%b, want all zero",
                            b1.busy, b1.sd_addr, b1.h_rdata, b1.e_rdata, b1.owner);
      end
      b1.h_req = 0;
      tick();
      @(negedge clk);
      checks++;
      if (b1.h_ack !== 1'b0 || b1.busy !== 1'b0) begin
         errors++; $display("FAIL rst_noack: ack=%b busy=%b, want 0 0", b1.h_ack, b1.busy);
      end
      tick();
      rst_n = 1'b1;
      b1.fpga_mode = 1;
      b1.h_req = 1; b1.h_we = 1; b1.h_addr = 7'h07; b1.h_wdata = 8'h99;
      b1.e_req = 1; b1.e_we = 1; b1.e_addr = 7'h08; b1.e_wdata = 8'h88;
      tick();
      @(negedge clk);
      checks++;
      if (b1.sd_we !== 1'b1 || b1.sd_addr !== 7'h07) begin
         errors++; $display("FAIL rst_tie_host: we=%b addr=%h, want 1 07", b1.sd_we, b1.sd_addr);
      end
      tick();
      @(negedge clk);
      checks++;
      if (b1.h_ack !== 1'b1 || b1.e_ack !== 1'b0) begin
         errors++; $display("FAIL rst_post_ack: h=%b e=%b, want 1 0", b1.h_ack, b1.e_ack);
      end
      tick();
      b1.h_req = 0;
      tick();
      @(negedge clk);
      checks++;
      if (b1.sd_addr !== 7'h08 || b1.sd_we !== 1'b1) begin
         errors++; $display("FAIL rst_eng_next: addr=%h we=%b, want 08 1", b1.sd_addr, b1.sd_we);
      end
      tick();
      tick();
      b1.e_req = 0; b1.fpga_mode = 0;
      tick();
   endtask

   task automatic test_rd_lat3();
      int ack_cyc;
      int ack_n;
      ack_cyc = -1;
      b3.fpga_mode = 1; b3.e_req = 1; b3.e_we = 0; b3.e_addr = 7'h21; b3.sd_data_i = 8'h3C;
      for (int c = 1; c <= 7; c++) begin
         tick();
         if (c == 6) b3.e_req = 0;
         @(negedge clk);
         if (b3.e_ack === 1'b1 && ack_cyc < 0) ack_cyc = c;
      end
      checks++;
      if (ack_cyc != 2 + LAT3 || b3.e_rdata !== 8'h3C) begin
         errors++; $display("FAIL lat3_eng: ack cycle=%0d rdata=%h, want %0d 3c", ack_cyc, b3.e_rdata, 2 + LAT3);
      end
      ack_cyc = -1; ack_n = 0;
      b3.h_req = 1; b3.h_we = 0; b3.h_addr = 7'h12; b3.sd_data_i = 8'hEE;
      for (int c = 1; c <= 7; c++) begin
         tick();
         if (c == 4) b3.sd_data_i = 8'h77;
         if (c == 5) b3.sd_data_i = 8'h11;
         if (c == 6) b3.h_req = 0;
         @(negedge clk);
         if (c == 1) begin
            checks++;
            if (b3.sd_addr !== 7'h12) begin
               errors++; $display("FAIL lat3_addr: addr=%h, want 12", b3.sd_addr);
            end
         end
         if (b3.h_ack === 1'b1) begin
            ack_n++;
            if (ack_cyc < 0) ack_cyc = c;
         end
      end
      checks++;
      if (ack_cyc != 5 || ack_n != 1 || b3.h_rdata !== 8'h77) begin
         errors++; $display("FAIL lat3_host: ack cycle=%0d count=%0d rdata=%h, want 5 1 77", ack_cyc, ack_n, b3.h_rdata);
      end
      checks++;
      if (b3.e_rdata !== 8'h3C) begin
         errors++; $display("FAIL lat3_erdata: e_rdata=%h, want 3c", b3.e_rdata);
      end
   endtask

   // Model: grant rule, latency formula and per-port read data, tracked per transaction.
   task automatic test_random();
      logic       h_pend, e_pend, hw, ew, fm, el_h, el_e, w, lw, m_last;
      logic [6:0] ha, ea, la;
      logic [7:0] hd, ed, ld, d, cap, m_hrd, m_erd;
      int         wait_n;
      idle_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m_last = 1'b1; m_hrd = 8'h00; m_erd = 8'h00;
      h_pend = 0; e_pend = 0;
      hw = 0; ew = 0; ha = 0; ea = 0; hd = 0; ed = 0; cap = 0;
      for (int it = 0; it < 300; it++) begin
         if (!h_pend && $urandom_range(0, 1) == 1) begin
            h_pend = 1; hw = 1'($urandom); ha = 7'($urandom); hd = 8'($urandom);
         end
         if (!e_pend && $urandom_range(0, 1) == 1) begin
            e_pend = 1; ew = 1'($urandom); ea = 7'($urandom); ed = 8'($urandom);
         end
         fm = $urandom_range(0, 3) != 0;
         b1.fpga_mode = fm;
         b1.h_req = h_pend; b1.h_we = hw; b1.h_addr = ha; b1.h_wdata = hd;
         b1.e_req = e_pend; b1.e_we = ew; b1.e_addr = ea; b1.e_wdata = ed;
         el_h = h_pend;
         el_e = e_pend && fm;
         @(negedge clk);
         checks++;
         if (b1.busy !== 1'b0 || b1.h_ack !== 1'b0 || b1.e_ack !== 1'b0 || b1.sd_we !== 1'b0) begin
            errors++; $display("FAIL rnd_idle[%0d]: busy=%b ack=%b%b we=%b, want 0", it, b1.busy, b1.h_ack, b1.e_ack, b1.sd_we);
         end
         if (!el_h && !el_e) begin
            tick();
            continue;
         end
         w = (el_h && el_e) ? !m_last : el_e;
         m_last = w;
         lw = w ? ew : hw;
         la = w ? ea : ha;
         ld = w ? ed : hd;
         wait_n = lw ? 0 : LAT1;
         tick();
         if ($urandom_range(0, 1) == 1) begin
            if (w) begin
               b1.e_we = 1'($urandom); b1.e_addr = 7'($urandom); b1.e_wdata = 8'($urandom);
            end else begin
               b1.h_we = 1'($urandom); b1.h_addr = 7'($urandom); b1.h_wdata = 8'($urandom);
            end
         end
         b1.fpga_mode = 1'($urandom);
         d = 8'($urandom); b1.sd_data_i = d; cap = d;
         @(negedge clk);
         checks++;
         if (b1.sd_we !== lw || b1.sd_addr !== la || b1.sd_data_o !== ld || b1.busy !== 1'b1 ||
             b1.owner !== w || b1.h_ack !== 1'b0 || b1.e_ack !== 1'b0) begin
            errors++; $display("FAIL rnd_issue[%0d]: we=%b addr=%h do=%h owner=%b, want %b %h %h %b",
                               it, b1.sd_we, b1.sd_addr, b1.sd_data_o, b1.owner, lw, la, ld, w);
         end
         for (int k = 0; k < wait_n; k++) begin
            tick();
            d = 8'($urandom); b1.sd_data_i = d; cap = d;
            @(negedge clk);
            checks++;
            if (b1.busy !== 1'b1 || b1.h_ack !== 1'b0 || b1.e_ack !== 1'b0 || b1.sd_we !== 1'b0) begin
               errors++; $display("FAIL rnd_wait[%0d]: busy=%b ack=%b%b we=%b, want 1 00 0", it, b1.busy, b1.h_ack, b1.e_ack, b1.sd_we);
            end
         end
         tick();
         b1.sd_data_i = ~cap;
         if (!lw) begin
            if (w) m_erd = cap;
            else   m_hrd = cap;
         end
         @(negedge clk);
         checks++;
         if (b1.h_ack !== !w || b1.e_ack !== w || b1.h_rdata !== m_hrd || b1.e_rdata !== m_erd ||
             b1.owner !== w || b1.busy !== 1'b1 || b1.sd_we !== 1'b0 || b1.sd_addr !== la) begin
            errors++; $display("FAIL rnd_ack[%0d]: ack=%b%b hr=%h er=%h owner=%b, want %b%b %h %h %b",
                               it, b1.h_ack, b1.e_ack, b1.h_rdata, b1.e_rdata, b1.owner, !w, w, m_hrd, m_erd, w);
         end
         tick();
         if (w) e_pend = 0;
         else   h_pend = 0;
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      idle_inputs();
      test_reset();
      test_host_write();
      test_host_read();
      test_engine_blocked();
      test_back_to_back();
      test_reset_mid();
      test_rd_lat3();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sd_bus_arbiter.md
SD_BUS_ARBITER -- requirements
Module: sd_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, SD register address width.
REQ-002 Parameter DATA_W, default 8, SD register data width.
REQ-003 Parameter RD_LAT, default 1, range 1..4; cycles from sd_addr change to valid sd_data_i.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fpga_mode  in  1  1 = engine port eligible for grant.
- h_req/e_req  in  1  host (SPI link) / engine request.
- h_we/e_we  in  1  1 = write, 0 = read.
- h_addr/e_addr  in  ADDR_W  register address.
- h_wdata/e_wdata  in  DATA_W  write data.
- h_ack/e_ack  out  1  one-cycle completion pulse.
- h_rdata/e_rdata  out  DATA_W  read data.
- sd_addr  out  ADDR_W  SD controller register address.
- sd_we  out  1  SD register write strobe.
- sd_data_o  out  DATA_W  SD write data.
- sd_data_i  in  DATA_W  SD read data.
- busy  out  1  transaction in progress.
- owner  out  1  current or last grant: 0 host, 1 engine.

Function
REQ-006 The FSM SHALL have states IDLE, ISSUE, RD_WAIT, ACK.
REQ-007 Requests SHALL be sampled only in IDLE; on a grant, the owner's we/addr/wdata are latched and the FSM goes to ISSUE next cycle.
REQ-008 With fpga_mode=0, only h_req is eligible; e_req stays pending, unacked, with no timeout.
REQ-009 With fpga_mode=1 and both requesting, the port not granted last wins; with one requesting, that port wins.
REQ-010 The round-robin pointer SHALL update only on grant.
REQ-011 ISSUE lasts one cycle: sd_addr/sd_data_o driven from latches; sd_we=1 exactly this cycle if write.
REQ-012 Write: ISSUE -> ACK.
REQ-013 Read: ISSUE -> RD_WAIT for RD_LAT cycles; sd_data_i captured on the last RD_WAIT edge -> ACK.
REQ-014 In ACK, the owner's ack SHALL be 1 for exactly one cycle, with its rdata valid in that cycle (reads); FSM -> IDLE.
REQ-015 Latency from request sampled in IDLE (cycle 0): write ack in cycle 2; read ack in cycle 2+RD_LAT.
REQ-016 rdata of each port SHALL hold until that port's next read ack; writes leave rdata unchanged.
REQ-017 sd_addr and sd_data_o SHALL hold their last values outside ISSUE; sd_we=0 outside ISSUE.
REQ-018 busy=1 in ISSUE, RD_WAIT and ACK.
REQ-019 A requester SHALL drop req in the cycle after ack; a req still high in IDLE is a new request.
REQ-020 A request fields change before ack is ignored; the latched values are used.
REQ-021 A fpga_mode change mid-transaction SHALL NOT abort it; it affects the next IDLE arbitration only.

Reset
REQ-022 On rst_n=0, immediately: state IDLE; acks, sd_we, busy = 0; sd_addr, sd_data_o, rdata = 0; owner = 0; pointer = engine-last, so host wins the first tie.
REQ-023 Reset mid-transaction SHALL drop the transaction with no ack; the first grant after release occurs no earlier than the first edge with rst_n=1.

Structure
REQ-024 Package sd_bus_pkg SHALL hold the state enum, the port-id enum (PORT_HOST=0, PORT_ENG=1) and default widths.
REQ-025 Two-way round-robin grant logic SHALL be sub-module rr_arb2 (req[1:0], advance -> gnt[1:0], last pointer).

Verification
REQ-026 Host write addr 0x05 data 0xA3, fpga_mode=0 -> sd_we high in cycle 1 only, sd_addr=0x05, sd_data_o=0xA3; h_ack in cycle 2.
REQ-027 Host read addr 0x12, sd_data_i=0x5C, RD_LAT=1 -> h_ack in cycle 3 with h_rdata=0x5C; sd_we stays 0.
REQ-028 fpga_mode=0, e_req held 20 cycles -> no e_ack, no sd_we; then fpga_mode=1 -> engine granted, e_ack follows.
REQ-029 fpga_mode=1, both requesting continuously, writes -> grants alternate H,E,H,E; owner toggles per ACK.
REQ-030 rst_n low during RD_WAIT -> no ack, outputs at reset values immediately; a request after release completes normally.
REQ-031 RD_LAT=3 read, sd_data_i=0x77 valid from cycle 4 -> ack in cycle 5 with rdata=0x77; e_rdata unchanged by a host read.
